fibonacci_multi_lane: RTL
=========================

Name: fibonacci_multi_lane

Overview:
Parametrised Fibonacci-style sequence generator, successor to the fixed 16-bit single- and double-rate generators. It emits LANES consecutive terms per beat over a valid/ready stream and takes runtime seeds, so it also produces Lucas and arbitrary-seed sequences. A runtime term count bounds each run, and a sticky flag reports width overflow. Used as a self-checking stimulus source and as a throughput/width-scaling exercise.

Parameters:
W, 16, term width in bits (>=2)
LANES, 2, terms emitted per accepted beat (1..4)
CNT_W, 8, width of term-count input and internal remaining counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  launch a run; sampled only in IDLE
seed_a  in  W  first term of sequence
seed_b  in  W  second term of sequence
count  in  CNT_W  number of terms to emit (0 = start ignored)
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
out_data  out  LANES*W  lane i at bits [i*W +: W], lane 0 = earliest term
out_mask  out  LANES  bit i set = lane i carries a real term
out_last  out  1  final beat of run
busy  out  1  run in progress (state RUN)
overflow  out  1  sticky: an emitted term's true value >= 2^W

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. On rst: state IDLE; out_valid, out_data, out_mask, out_last, busy, overflow all 0; internal a/b/remaining/wrap flags 0.
- FSM states: IDLE and RUN.
- IDLE to RUN: requires start=1 and count!=0. Capture a<=seed_a, b<=seed_b, rem<=count. Clear a_wrap, b_wrap and overflow.
- Latency: out_valid=1 on the first cycle after start is sampled.
- start with count=0: no state change.
- start while in RUN: ignored.
- Term chain (combinational from registers): t0=a, t1=b, t(k)=t(k-1)+t(k-2) truncated to W, for k = 2 .. LANES+1.
- Wrap chain: wrap(t0)=a_wrap, wrap(t1)=b_wrap, wrap(tk)=carry_out(k) | wrap(t(k-1)) | wrap(t(k-2)).
- In RUN: out_valid=1, busy=1.
  - out_mask[i] = (i < rem).
  - lane i = t(i) if masked in, else 0.
  - out_last = (rem <= LANES).
- In IDLE: out_valid, out_data, out_mask and out_last are 0.
- Accept = out_valid & out_ready. On accept:
  - a <= t(LANES), b <= t(LANES+1).
  - a_wrap/b_wrap take the wraps of those terms.
  - rem <= rem - LANES, saturating at 0.
  - overflow |= OR of wrap(t(i)) over masked-in lanes.
  - if out_last, go to IDLE.
- No accept: all registers hold. out_data, out_mask and out_last stay stable while out_valid=1 and out_ready=0. Valid is never withdrawn.
- overflow holds its value in IDLE after a run; it is cleared only by rst or the next accepted start.
- out_ready is ignored in IDLE.
- Reset mid-run: abort immediately, all outputs to reset values on the next cycle. No partial beat is delivered.
- Seeds are unrestricted. t0/t1 are passed through unmodified even if seed_a > seed_b.
- LANES=1 degenerates to one term per beat, matching the single-rate generator's sequence for seeds 1,1.

Test Plan:
- W=16, LANES=2, seeds 1,1, count=10, ready=1: beats (1,1),(2,3),(5,8),(13,21),(34,55); mask=11 on every beat; out_last only on beat 5; busy=0 the cycle after; overflow=0.
- Same seeds, count=5: third beat data (5,0), mask=01, last=1; then IDLE.
- Backpressure, count=10: out_ready=0 for 3 cycles while beat (2,3) is presented. Data, mask and valid stay stable throughout; the next accepted beat is (5,8), with no skipped or duplicated terms.
- Overflow, seeds 1,1:
  - count=24: last beat (28657,46368), overflow=0.
  - count=25: beat 13 = (9489,0) [75025 mod 65536], mask=01, overflow=1, still 1 in IDLE.
  - A new start clears overflow.
- Lucas seeds 2,1, count=4: beats (2,1),(3,4). A start pulse during beat 1 is ignored. A start with count=0 in IDLE leaves busy=0.
- Reset mid-run: assert rst after 2 accepted beats. The next cycle shows out_valid=0, busy=0, overflow=0. A fresh start with seeds 1,1 restarts at (1,1).
- LANES=3, seeds 1,1, count=7: beats (1,1,2),(3,5,8),(13,0,0) with mask=001 and last=1.

Source files
------------

// File: rtl/fibonacci_multi_lane.sv
// ---------------------------------------------------------------------------
// fibonacci_multi_lane
//
// Fibonacci-style sequence generator that emits LANES consecutive terms per
// beat on a valid/ready stream. Seeds are taken at runtime, so Fibonacci,
// Lucas and arbitrary-seed sequences all come out of the same block. A
// runtime term count bounds each run and a sticky flag reports whenever an
// emitted term's true value no longer fits in W bits.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   start      launch a run (sampled only while idle)
//   seed_a     first term of the sequence
//   seed_b     second term of the sequence
//   count      number of terms to emit (0 means start is ignored)
//   out_valid  a beat is being presented
//   out_ready  consumer accepts the presented beat
//   out_data   lane i at bits [i*W +: W], lane 0 is the earliest term
//   out_mask   bit i set when lane i carries a real term
//   out_last   final beat of the run
//   busy       a run is in progress
//   overflow   sticky: some emitted term's true value was >= 2^W
// ---------------------------------------------------------------------------
module fibonacci_multi_lane #(
    parameter int W     = 16,
    parameter int LANES = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         seed_a,
    input  logic [W-1:0]         seed_b,
    input  logic [CNT_W-1:0]     count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic [LANES-1:0]     out_mask,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overflow
);

    // The chain holds the two stored terms plus LANES further terms, so
    // that both the emitted lanes and the next a/b pair are available.
    localparam int NT = LANES + 2;
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    logic [W-1:0]     a, b;
    logic             a_wrap, b_wrap;
    logic [CNT_W-1:0] rem;

    logic [W-1:0] term      [NT];
    logic         term_wrap [NT];
    logic [W:0]   sum       [NT];
    logic         accept;
    logic         beat_wrap;

    // Term chain. Each term is the truncated sum of the previous two; its
    // wrap flag records that its true value has left the W-bit range,
    // either through its own carry or because an ancestor already had.
    always_comb begin
        for (int k = 0; k < NT; k++) begin
            sum[k] = '0;
        end
        term[0]      = a;
        term[1]      = b;
        term_wrap[0] = a_wrap;
        term_wrap[1] = b_wrap;
        for (int k = 2; k < NT; k++) begin
            sum[k]       = {1'b0, term[k-1]} + {1'b0, term[k-2]};
            term[k]      = sum[k][W-1:0];
            term_wrap[k] = sum[k][W] | term_wrap[k-1] | term_wrap[k-2];
        end
    end

    // Beat presentation. Outputs are derived purely from registered state,
    // so they stay stable under backpressure. Lanes past the remaining count
    // are zeroed and do not contribute to the overflow flag.
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        out_mask  = '0;
        out_data  = '0;
        beat_wrap = 1'b0;
        if (state == RUN) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (rem <= LANES_C);
            for (int i = 0; i < LANES; i++) begin
                if (CNT_W'(i) < rem) begin
                    out_mask[i]         = 1'b1;
                    out_data[i*W +: W]  = term[i];
                    beat_wrap           = beat_wrap | term_wrap[i];
                end
            end
        end
    end

    assign accept = out_valid & out_ready;

    // Next-state logic: a run begins only with a nonzero count and ends
    // when the final beat is taken by the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && (count != '0)) state_next = RUN;
            RUN:  if (accept && out_last)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. A launch loads the seeds and clears the sticky
    // overflow; each accepted beat advances the sequence by LANES terms and
    // folds the masked lanes' wrap flags into overflow. Without an accept
    // everything holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            a_wrap   <= 1'b0;
            b_wrap   <= 1'b0;
            rem      <= '0;
            overflow <= 1'b0;
        end else if (state == IDLE) begin
            if (start && (count != '0)) begin
                a        <= seed_a;
                b        <= seed_b;
                rem      <= count;
                a_wrap   <= 1'b0;
                b_wrap   <= 1'b0;
                overflow <= 1'b0;
            end
        end else if (accept) begin
            a        <= term[LANES];
            b        <= term[LANES+1];
            a_wrap   <= term_wrap[LANES];
            b_wrap   <= term_wrap[LANES+1];
            rem      <= (rem <= LANES_C) ? '0 : rem - LANES_C;
            overflow <= overflow | beat_wrap;
        end
    end

endmodule
